// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 host transmitter and the scan-code
// receiver.
//   ps2_state_e  : transmitter FSM encoding
//   DATA_BITS    : payload width of a PS/2 frame
//   LAST_BIT_IDX : index of the stop bit within the transmit bit counter
//   odd_parity() : parity bit that makes the frame's count of ones odd
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam int DATA_BITS    = 8;
  localparam int LAST_BIT_IDX = 9;

  function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: brings one raw PS/2 pin into the clk domain and debounces it.
//   clk, rst_n : system clock, synchronous active-low reset
//   i_raw      : raw pin, asynchronous to clk
//   o_level    : filtered level; resets to 1 (idle line)
// The level only moves after FILTER_CYCLES consecutive synchronized samples
// that all disagree with it, so short glitches are swallowed.
module ps2_line_filter #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        // this is the FILTER_CYCLES-th disagreeing sample in a row
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/ps2_host_transmitter.sv
// ps2_host_transmitter: sends one command byte from the host to a PS/2 device.
//   clk, rst_n          : system clock, synchronous active-low reset
//   txData/txValid/txReady : byte handshake, accepted when txValid & txReady
//   ps2ClkIn/ps2DataIn  : raw PS/2 pins (shared with the receiver)
//   ps2ClkOutEn/ps2DataOutEn : 1 = pull the line low, 0 = release (open drain)
//   busy                : transfer in progress, receiver must ignore the lines
//   txDone/txError      : one-cycle completion / failure pulses
// Sequence: hold clock low (INHIBIT), pull data low (REQ, start bit), release
// clock and present one bit per device clock fall (SEND), then check the
// device's acknowledge (ACK) and wait for both lines to go idle (WAIT_IDLE).
module ps2_host_transmitter
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int FILTER_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] txData,
  input  logic                 txValid,
  output logic                 txReady,
  input  logic                 ps2ClkIn,
  input  logic                 ps2DataIn,
  output logic                 ps2ClkOutEn,
  output logic                 ps2DataOutEn,
  output logic                 busy,
  output logic                 txDone,
  output logic                 txError
);

  localparam int ICW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ICW-1:0] INH_LAST = ICW'(INHIBIT_CYCLES - 1);
  localparam logic [TCW-1:0] TO_LIMIT = TCW'(TIMEOUT_CYCLES);
  localparam logic [3:0]     STOP_IDX = 4'(LAST_BIT_IDX);

  ps2_state_e r_state;
  ps2_state_e w_next;

  logic [ICW-1:0]        r_icnt;
  logic [TCW-1:0]        r_tcnt;
  logic [LAST_BIT_IDX:0] r_shift;    // {stop, parity, data}; bit 0 goes next
  logic [3:0]            r_bit_cnt;
  logic                  r_data_en;
  logic                  r_done;
  logic                  r_err;
  logic                  r_clk_prev;

  logic w_clk_lvl;
  logic w_data_lvl;
  logic w_fall;
  logic w_hs;
  logic w_timed;
  logic w_timeout;

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (ps2ClkIn),
    .o_level (w_clk_lvl)
  );

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (ps2DataIn),
    .o_level (w_data_lvl)
  );

  assign w_fall    = r_clk_prev & ~w_clk_lvl;
  assign w_hs      = txValid & (r_state == IDLE);
  assign w_timed   = (r_state == SEND) | (r_state == ACK) | (r_state == WAIT_IDLE);
  // timeout wins over a coincident clock fall
  assign w_timeout = w_timed & (r_tcnt == TO_LIMIT);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (txValid) w_next = INHIBIT;
      INHIBIT:   if (r_icnt == INH_LAST) w_next = REQ;
      REQ:       w_next = SEND;
      SEND: begin
        if (w_timeout)                          w_next = IDLE;
        else if (w_fall && r_bit_cnt == STOP_IDX) w_next = ACK;
      end
      ACK: begin
        if (w_timeout)   w_next = IDLE;
        else if (w_fall) w_next = w_data_lvl ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (w_timeout)                  w_next = IDLE;
        else if (w_clk_lvl && w_data_lvl) w_next = IDLE;
      end
      default:   w_next = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    txReady      = (r_state == IDLE);
    busy         = (r_state != IDLE);
    ps2ClkOutEn  = (r_state == INHIBIT) | (r_state == REQ);
    ps2DataOutEn = 1'b0;
    if (r_state == REQ)  ps2DataOutEn = 1'b1;
    if (r_state == SEND) ps2DataOutEn = r_data_en;
    txDone       = r_done;
    txError      = r_err;
  end

  // datapath: counters, shift register, registered data enable and pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_icnt     <= '0;
      r_tcnt     <= '0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_data_en  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_prev <= w_clk_lvl;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_shift <= {1'b1, odd_parity(txData), txData};
            r_icnt  <= '0;
          end
        end
        INHIBIT: r_icnt <= r_icnt + 1'b1;
        REQ: begin
          // the first SEND cycle counts as cycle 1 of the timeout window
          r_tcnt    <= TCW'(1);
          r_bit_cnt <= '0;
          r_data_en <= 1'b1;   // keep the start bit on the line
        end
        SEND: begin
          if (w_timeout) begin
            r_err     <= 1'b1;
            r_data_en <= 1'b0;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
            if (w_fall) begin
              r_data_en <= ~r_shift[0];
              r_shift   <= {1'b1, r_shift[LAST_BIT_IDX:1]};
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        ACK: begin
          if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
            if (w_fall && w_data_lvl) r_err <= 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
            if (w_clk_lvl && w_data_lvl) r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
